// File: rtl/weight_update.sv
// Learning-rate-scaled, saturated weight update over a VECTOR_SIZE^2 matrix, TILING cells per clock.
// Latency: ceil(N/TILING) cycles from accepted start to finish; no backpressure, inputs held stable by upstream.
module weight_update #(
    parameter int VECTOR_SIZE = 5,
    parameter int CELL_WIDTH  = 8,
    parameter int TILING      = 2,
    parameter int LR_SHIFT    = 4
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic                                              start,
    input  logic [VECTOR_SIZE*VECTOR_SIZE*2*CELL_WIDTH-1:0]   product,
    input  logic [VECTOR_SIZE*VECTOR_SIZE*CELL_WIDTH-1:0]     weights_in,
    output logic [VECTOR_SIZE*VECTOR_SIZE*CELL_WIDTH-1:0]     weights_out,
    output logic [$clog2(VECTOR_SIZE*VECTOR_SIZE+1)-1:0]      sat_count,
    output logic                                              busy,
    output logic                                              finish
);

    localparam int N   = VECTOR_SIZE * VECTOR_SIZE;
    localparam int PW  = 2 * CELL_WIDTH;
    localparam int T   = (N + TILING - 1) / TILING;
    localparam int CTW = (T > 1) ? $clog2(T) : 1;
    localparam int SW  = $clog2(N + 1);
    localparam int TSW = $clog2(TILING + 1);

    localparam logic signed [PW:0] MAX_V = (PW+1)'(2**(CELL_WIDTH-1) - 1);
    localparam logic signed [PW:0] MIN_V = -((PW+1)'(2**(CELL_WIDTH-1)));

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [CTW-1:0] tile_cnt;
    logic           last_tile;

    logic [31:0]                  cell_idx  [TILING];
    logic [31:0]                  safe_idx  [TILING];
    logic                         cell_en   [TILING];
    logic signed [PW-1:0]         prod_c    [TILING];
    logic signed [PW-1:0]         delta_c   [TILING];
    logic signed [CELL_WIDTH-1:0] wt_c      [TILING];
    logic signed [PW:0]           diff_c    [TILING];
    logic [CELL_WIDTH-1:0]        cell_val  [TILING];
    logic [TSW-1:0]               tile_sat;

    assign last_tile = (tile_cnt == CTW'(T - 1));
    assign busy      = (state == RUN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = RUN;
            RUN:     if (last_tile) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Cells past N in the final tile read cell 0 harmlessly and are masked by cell_en.
    always_comb begin
        tile_sat = '0;
        for (int t = 0; t < TILING; t++) begin
            cell_idx[t] = 32'(tile_cnt) * TILING + t;
            cell_en[t]  = (cell_idx[t] < N);
            safe_idx[t] = cell_en[t] ? cell_idx[t] : 32'd0;
            prod_c[t]   = product[safe_idx[t]*PW +: PW];
            wt_c[t]     = weights_in[safe_idx[t]*CELL_WIDTH +: CELL_WIDTH];
            delta_c[t]  = prod_c[t] >>> LR_SHIFT;
            diff_c[t]   = (PW+1)'(wt_c[t]) - (PW+1)'(delta_c[t]);
            cell_val[t] = diff_c[t][CELL_WIDTH-1:0];
            if (diff_c[t] > MAX_V) begin
                cell_val[t] = MAX_V[CELL_WIDTH-1:0];
                if (cell_en[t]) tile_sat = tile_sat + TSW'(1);
            end else if (diff_c[t] < MIN_V) begin
                cell_val[t] = MIN_V[CELL_WIDTH-1:0];
                if (cell_en[t]) tile_sat = tile_sat + TSW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tile_cnt    <= '0;
            finish      <= 1'b0;
            sat_count   <= '0;
            weights_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tile_cnt <= '0;
                    if (start) begin
                        finish    <= 1'b0;
                        sat_count <= '0;
                    end
                end
                RUN: begin
                    for (int t = 0; t < TILING; t++) begin
                        if (cell_en[t]) begin
                            weights_out[safe_idx[t]*CELL_WIDTH +: CELL_WIDTH] <= cell_val[t];
                        end
                    end
                    sat_count <= sat_count + SW'(tile_sat);
                    if (last_tile) begin
                        tile_cnt <= '0;
                        finish   <= 1'b1;
                    end else begin
                        tile_cnt <= tile_cnt + CTW'(1);
                    end
                end
                default: tile_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_update.sv
// Randomized and directed bench for weight_update: driver pushes expected passes, monitor checks on finish.
module tb_weight_update;

    localparam int VS = 5;
    localparam int CW = 8;
    localparam int N  = VS * VS;
    localparam int LR = 4;
    localparam int T  = 13;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [N*2*CW-1:0]     product;
    logic [N*CW-1:0]       weights_in;
    logic [N*CW-1:0]       weights_out;
    logic [4:0]            sat_count;
    logic                  busy;
    logic                  finish;

    weight_update #(.VECTOR_SIZE(VS), .CELL_WIDTH(CW), .TILING(2), .LR_SHIFT(LR)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .product     (product),
        .weights_in  (weights_in),
        .weights_out (weights_out),
        .sat_count   (sat_count),
        .busy        (busy),
        .finish      (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N*CW-1:0] w;
        int              sat;
    } exp_t;

    exp_t sb[$];
    int   p_arr [N];
    int   w_arr [N];
    int   checks = 0;
    int   errors = 0;
    logic fin_prev;

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [N*CW-1:0] act, input logic [N*CW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: floor division by the learning-rate divisor, then clamp to the cell range.
    task automatic push_expected();
        exp_t e;
        int   div;
        int   p;
        int   delta;
        int   d;
        div   = 1 << LR;
        e.w   = '0;
        e.sat = 0;
        for (int i = 0; i < N; i++) begin
            p     = p_arr[i];
            delta = (p >= 0) ? p / div : -((-p + div - 1) / div);
            d     = w_arr[i] - delta;
            if (d > 127) begin
                d = 127;
                e.sat++;
            end else if (d < -128) begin
                d = -128;
                e.sat++;
            end
            e.w[i*CW +: CW] = 8'(d);
        end
        sb.push_back(e);
    endtask

    task automatic apply_inputs();
        for (int i = 0; i < N; i++) begin
            product[i*2*CW +: 2*CW] = 16'(p_arr[i]);
            weights_in[i*CW +: CW]  = 8'(w_arr[i]);
        end
    endtask

    task automatic fill(input int p, input int w);
        for (int i = 0; i < N; i++) begin
            p_arr[i] = p;
            w_arr[i] = w;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 1) p_arr[i] = int'($urandom_range(0, 65535)) - 32768;
            else                           p_arr[i] = int'($urandom_range(0, 4095)) - 2048;
            w_arr[i] = int'($urandom_range(0, 255)) - 128;
        end
    endtask

    // Runs one pass; pulse_at >= 0 re-asserts start for one cycle mid-pass.
    task automatic run_pass(input string name, input int pulse_at);
        int n;
        int g;
        apply_inputs();
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        g = 0;
        while (!finish && g < 60) begin
            if (busy) n++;
            start = (g == pulse_at);
            @(negedge clk);
            g++;
        end
        start = 1'b0;
        check_int({name, "_busy_cycles"}, n, T);
        check_int({name, "_finish"}, int'(finish), 1);
        check_int({name, "_busy_at_finish"}, int'(busy), 0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            fin_prev = 1'b0;
        end else begin
            if (finish && !fin_prev) begin
                if (sb.size() == 0) begin
                    check_int("unexpected_finish", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_vec("weights_out", weights_out, e.w);
                    check_int("sat_count", int'(sat_count), e.sat);
                end
            end
            fin_prev = finish;
        end
    end

    initial begin
        int g;
        rst        = 1'b0;
        start      = 1'b0;
        product    = '0;
        weights_in = '0;
        repeat (2) @(negedge clk);
        check_vec("reset_weights", weights_out, '0);
        check_int("reset_sat", int'(sat_count), 0);
        check_int("reset_finish", int'(finish), 0);
        check_int("reset_busy", int'(busy), 0);
        rst = 1'b1;
        @(negedge clk);

        fill(16, 10);
        run_pass("nominal", -1);

        fill(-256, 120);
        run_pass("pos_sat", -1);

        fill(32767, -100);
        run_pass("neg_sat", -1);

        for (int i = 0; i < N; i++) begin
            p_arr[i] = (i % 2 == 0) ? -1 : 15;
            w_arr[i] = (i % 2 == 0) ? 0 : 5;
        end
        p_arr[N-1] = 32;
        w_arr[N-1] = 3;
        run_pass("rounding_tail", -1);

        fill_random();
        run_pass("start_in_run", 5);

        // Start held: finish must pulse for exactly one cycle between two passes.
        fill_random();
        apply_inputs();
        push_expected();
        @(negedge clk);
        start = 1'b1;
        g = 0;
        @(negedge clk);
        while (!finish && g < 60) begin
            @(negedge clk);
            g++;
        end
        check_int("held_first_finish", int'(finish), 1);
        fill_random();
        apply_inputs();
        push_expected();
        @(negedge clk);
        check_int("held_finish_one_cycle", int'(finish), 0);
        check_int("held_second_busy", int'(busy), 1);
        start = 1'b0;
        g = 0;
        while (!finish && g < 60) begin
            @(negedge clk);
            g++;
        end
        check_int("held_second_finish", int'(finish), 1);
        @(negedge clk);

        // Asynchronous reset in the middle of a pass.
        fill_random();
        apply_inputs();
        push_expected();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_vec("midreset_weights", weights_out, '0);
        check_int("midreset_finish", int'(finish), 0);
        check_int("midreset_sat", int'(sat_count), 0);
        check_int("midreset_busy", int'(busy), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill_random();
        run_pass("after_reset", -1);

        for (int k = 0; k < 8; k++) begin
            fill_random();
            run_pass("random", -1);
        end

        repeat (3) @(negedge clk);
        check_int("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
